// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I) and memory (D) pipeline stages.
// D requests win ties; a streak counter forces an I grant after MAX_D_STREAK back-to-back D grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic [DW-1:0] IRData,
  output logic [DW-1:0] DRData,
  output logic          IDone,
  output logic          DDone,
  output logic          BusErr,
  output logic          StallI,
  output logic          StallD,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemReady
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [3:0] MaxStreak   = 4'(MAX_D_STREAK);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t     state, nextState;
  owner_t     owner;
  logic [3:0] streak;
  logic [7:0] timeoutCnt;
  logic       grantI, grantD, complete, timedOut;

  assign StallI = IReq & ~IDone;
  assign StallD = DReq & ~DDone;

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // A real MemReady wins over a timeout landing in the same cycle.
  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    complete  = 1'b0;
    timedOut  = 1'b0;
    unique case (state)
      IDLE: begin
        if (IReq || DReq) begin
          nextState = BUSY;
          if (IReq && (!DReq || streak == MaxStreak)) grantI = 1'b1;
          else                                        grantD = 1'b1;
        end
      end
      BUSY: begin
        if (MemReady) begin
          complete  = 1'b1;
          nextState = RESP;
        end else if (timeoutCnt == TimeoutLast) begin
          timedOut  = 1'b1;
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      owner      <= OWN_I;
      streak     <= '0;
      timeoutCnt <= '0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      IRData     <= '0;
      DRData     <= '0;
      IDone      <= 1'b0;
      DDone      <= 1'b0;
      BusErr     <= 1'b0;
    end else begin
      IDone <= 1'b0;
      DDone <= 1'b0;
      if (state == RESP) BusErr <= 1'b0;

      if (grantI) begin
        owner      <= OWN_I;
        MemReq     <= 1'b1;
        MemWe      <= 1'b0;
        MemAddr    <= IAddr;
        MemWData   <= '0;
        timeoutCnt <= '0;
        streak     <= '0;
      end

      // Streak only grows while fetch is actually being held off.
      if (grantD) begin
        owner      <= OWN_D;
        MemReq     <= 1'b1;
        MemWe      <= DWe;
        MemAddr    <= DAddr;
        MemWData   <= DWData;
        timeoutCnt <= '0;
        if (!IReq)                  streak <= '0;
        else if (streak != MaxStreak) streak <= streak + 4'd1;
      end

      if (state == BUSY && !complete && !timedOut)
        timeoutCnt <= timeoutCnt + 8'd1;

      if (complete || timedOut) begin
        MemReq <= 1'b0;
        BusErr <= timedOut;
        if (owner == OWN_D) begin
          DDone  <= 1'b1;
          DRData <= (complete && !MemWe) ? MemRData : '0;
        end else begin
          IDone  <= 1'b1;
          IRData <= complete ? MemRData : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder model answers MemReq,
// and a monitor pops expected completions whenever IDone/DDone fires.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWData;
  logic [31:0] IRData, DRData;
  logic        IDone, DDone, BusErr, StallI, StallD;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        MemReady;

  typedef struct packed {
    logic        isD;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbQ[$];
  int          testsRun = 0;
  int          failCnt  = 0;

  bit          respEnable  = 0;
  bit          respFixed   = 0;
  bit          injectStale = 0;
  int          respLat     = 0;
  logic [31:0] respData    = '0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .IRData(IRData), .DRData(DRData), .IDone(IDone), .DDone(DDone), .BusErr(BusErr),
    .StallI(StallI), .StallD(StallD),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: MemReady pulses in the (respLat+1)-th cycle of MemReq.
  initial begin : responder
    int busyCnt;
    busyCnt  = 0;
    MemReady = 1'b0;
    MemRData = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (injectStale) begin
        busyCnt  = 0;
        MemReady = 1'b1;
        MemRData = 32'hBAD0BAD0;
      end else if (MemReq && respEnable) begin
        busyCnt++;
        if (busyCnt == respLat + 1) begin
          MemReady = 1'b1;
          MemRData = respFixed ? respData : (MemAddr ^ 32'hA5A50000);
        end else begin
          MemReady = 1'b0;
          MemRData = '0;
        end
      end else begin
        busyCnt  = 0;
        MemReady = 1'b0;
        MemRData = '0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (IDone || DDone) begin
        if (IDone && DDone) begin
          testsRun++;
          failCnt++;
          $display("[TB] FAIL bothDone: got IDone=1 DDone=1, required only one");
        end else if (sbQ.size() == 0) begin
          testsRun++;
          failCnt++;
          $display("[TB] FAIL unexpectedDone: got IDone=%0b DDone=%0b, required none", IDone, DDone);
        end else begin
          e = sbQ.pop_front();
          checkOutput("donePort", {31'd0, DDone}, {31'd0, e.isD});
          checkOutput("rData", DDone ? DRData : IRData, e.data);
          checkOutput("busErr", {31'd0, BusErr}, {31'd0, e.err});
        end
      end
    end
  end

  // Issues one access, checks the Mem* bus and stall every cycle, drops Req on Done.
  task automatic applyStimulus(input bit isD, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input bit expErr, input int budget, output int reqCycles);
    bit got;
    bit done;
    bit stall;
    sbQ.push_back('{isD: isD, data: expData, err: expErr});
    if (isD) begin
      DReq = 1'b1; DWe = we; DAddr = addr; DWData = wdata;
    end else begin
      IReq = 1'b1; IAddr = addr;
    end
    reqCycles = 0;
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge CLK);
      if (MemReq) begin
        reqCycles++;
        checkOutput("memAddr", MemAddr, addr);
        checkOutput("memWe", {31'd0, MemWe}, {31'd0, isD ? we : 1'b0});
        checkOutput("memWData", MemWData, isD ? wdata : 32'd0);
      end
      done  = isD ? DDone : IDone;
      stall = isD ? StallD : StallI;
      checkOutput("stall", {31'd0, stall}, {31'd0, ~done});
      if (done) begin
        got = 1;
        if (isD) DReq = 1'b0;
        else     IReq = 1'b0;
      end
    end
    if (!got) begin
      testsRun++;
      failCnt++;
      $display("[TB] FAIL doneTimeout: got no Done in %0d cycles, required one", budget);
      IReq = 1'b0;
      DReq = 1'b0;
    end
  endtask

  initial begin : stimulus
    int reqCycles;
    int doneCnt;
    bit finished;

    Reset = 1'b1;
    IReq = 0; DReq = 0; DWe = 0;
    IAddr = '0; DAddr = '0; DWData = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rstMemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("rstMemWe", {31'd0, MemWe}, 32'd0);
    checkOutput("rstMemAddr", MemAddr, 32'd0);
    checkOutput("rstMemWData", MemWData, 32'd0);
    checkOutput("rstDone", {30'd0, IDone, DDone}, 32'd0);
    checkOutput("rstBusErr", {31'd0, BusErr}, 32'd0);
    checkOutput("rstIRData", IRData, 32'd0);
    checkOutput("rstDRData", DRData, 32'd0);
    Reset = 1'b0;
    @(negedge CLK);

    // Single I read, ready three cycles after MemReq rises
    respEnable = 1; respFixed = 1; respData = 32'h8C220004; respLat = 3;
    applyStimulus(1'b0, 1'b0, 32'h0040_0000, 32'd0, 32'h8C220004, 1'b0, 20, reqCycles);
    checkOutput("iReadReqCycles", reqCycles, 32'd4);
    @(negedge CLK);
    checkOutput("iDonePulse", {31'd0, IDone}, 32'd0);

    // D write; memory returns junk that must not reach DRData
    respData = 32'hFFFF0000; respLat = 1;
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 20, reqCycles);
    checkOutput("dWriteReqCycles", reqCycles, 32'd2);
    @(negedge CLK);
    checkOutput("dDonePulse", {31'd0, DDone}, 32'd0);
    checkOutput("iRDataHold", IRData, 32'h8C220004);

    // Both ports held: D,D,D,D,I,D,D,D,D,I
    respFixed = 0; respLat = 0;
    for (int k = 0; k < 10; k++)
      sbQ.push_back('{isD: (k % 5 != 4), data: ((k % 5 != 4) ? 32'hA5A50200 : 32'hA5A50040), err: 1'b0});
    IReq = 1; IAddr = 32'h40;
    DReq = 1; DAddr = 32'h200; DWe = 0; DWData = '0;
    doneCnt = 0;
    finished = 0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge CLK);
      if (IDone || DDone) doneCnt++;
      if (doneCnt == 10) begin
        IReq = 0; DReq = 0; finished = 1;
      end
    end
    if (!finished) begin
      testsRun++;
      failCnt++;
      $display("[TB] FAIL streakTimeout: got %0d completions, required 10", doneCnt);
      IReq = 0; DReq = 0;
    end
    @(negedge CLK);

    // Memory never answers: 64 MemReq cycles then error completion
    respEnable = 0;
    applyStimulus(1'b0, 1'b0, 32'h0000_0080, 32'd0, 32'd0, 1'b1, 100, reqCycles);
    checkOutput("timeoutReqCycles", reqCycles, 32'd64);
    @(negedge CLK);

    // MemReady coincides with the timeout limit: normal completion
    respEnable = 1; respFixed = 1; respData = 32'h1234; respLat = 63;
    applyStimulus(1'b1, 1'b0, 32'h300, 32'd0, 32'h1234, 1'b0, 100, reqCycles);
    checkOutput("edgeReqCycles", reqCycles, 32'd64);
    @(negedge CLK);

    // Reset during a D access, then a stale MemReady in IDLE, then an I fetch
    respEnable = 0;
    DReq = 1; DWe = 0; DAddr = 32'h380; DWData = '0;
    repeat (3) @(negedge CLK);
    checkOutput("preRstMemReq", {31'd0, MemReq}, 32'd1);
    Reset = 1'b1;
    DReq = 0;
    @(negedge CLK);
    checkOutput("midRstMemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("midRstDDone", {31'd0, DDone}, 32'd0);
    Reset = 1'b0;
    injectStale = 1;
    @(negedge CLK);
    injectStale = 0;
    checkOutput("staleMemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("staleDDone", {31'd0, DDone}, 32'd0);
    respEnable = 1; respFixed = 0; respLat = 2;
    applyStimulus(1'b0, 1'b0, 32'h44, 32'd0, 32'hA5A50044, 1'b0, 20, reqCycles);
    checkOutput("postRstReqCycles", reqCycles, 32'd3);
    repeat (2) @(negedge CLK);

    checkOutput("sbDrain", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequencer/arbiter that shares one single-port unified instruction/data memory between the fetch stage (I port, read-only) and the memory stage (D port, read/write) of the MIPS pipeline. It grants one requester at a time and drives a multi-cycle ready/handshake memory interface. It returns read data and a one-cycle done pulse to the winner, and generates per-port stall signals for the hazard logic. Data requests have priority, and an anti-starvation counter guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_D_STREAK, 4, max consecutive D grants while IReq is pending before one I grant is forced (legal range 1..15)
TIMEOUT, 64, max BUSY cycles without MemReady before the access aborts with error (legal range 2..255)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
IReq  in  1  fetch request, held until IDone
IAddr  in  AW  fetch address, stable while IReq
DReq  in  1  data request, held until DDone
DWe  in  1  data write enable, stable while DReq
DAddr  in  AW  data address
DWData  in  DW  data write data
IRData  out  DW  fetch read data, valid in IDone cycle
DRData  out  DW  data read data, valid in DDone cycle (0 on writes)
IDone  out  1  one-cycle completion pulse, I port
DDone  out  1  one-cycle completion pulse, D port
BusErr  out  1  high with IDone/DDone when the access timed out
StallI  out  1  IReq & ~IDone (combinational)
StallD  out  1  DReq & ~DDone (combinational)
MemReq  out  1  memory access request (registered)
MemWe  out  1  memory write enable (registered)
MemAddr  out  AW  memory address (registered)
MemWData  out  DW  memory write data (registered)
MemRData  in  DW  memory read data, valid with MemReady
MemReady  in  1  memory completion, one cycle

Behaviour:
- Reset values: state IDLE; all outputs, latched address/data registers, streak counter, and timeout counter are 0. Reset asserted mid-access aborts it: MemReq is 0 the following cycle, no Done pulse is produced, and a stale MemReady seen in IDLE is ignored.
- States: IDLE, BUSY, RESP. A grant-owner register (I or D) is held through BUSY and RESP.
- IDLE:
  - If DReq or IReq is high, pick the winner, latch its addr/we/wdata into the Mem* registers, set MemReq=1 (visible next cycle), clear the timeout counter, and go to BUSY.
  - I-port grants always drive MemWe=0 and MemWData=0.
- Arbitration:
  - DReq only: D wins. IReq only: I wins.
  - Both high: D wins unless streak==MAX_D_STREAK, in which case I wins.
  - Streak counter increments (saturating at MAX_D_STREAK) on a D grant with IReq high. It clears on any I grant and on a D grant with IReq low.
- BUSY:
  - MemReq and Mem* values are held stable. The timeout counter increments each cycle.
  - On MemReady: capture MemRData into the owner's RData register (DRData=0 if write), deassert MemReq next cycle, go to RESP.
  - If the timeout counter reaches TIMEOUT-1 without MemReady: capture 0, set BusErr, deassert MemReq, go to RESP.
  - MemReady and timeout arriving in the same cycle count as a normal completion (BusErr=0).
- RESP:
  - Exactly one cycle. The owner's Done=1; BusErr holds its value. Next state is IDLE.
  - Done is registered (asserted during RESP), so the requester drops Req the cycle after Done. IDLE therefore never re-grants a completed request.
- Latency: request seen in IDLE at cycle 0 → MemReq=1 at cycle 1 → MemReady at cycle k≥1 → Done at cycle k+1 → next arbitration at cycle k+2.
- RData registers hold their value after Done until the next completion for that port.
- Req dropped while BUSY (illegal) does not abort the access; Done still pulses.
- MemReady outside BUSY is ignored.

Test Plan:
- Single I read, memory ready 3 cycles after MemReq rises, MemRData=0x8C220004 → IDone in exactly one cycle, IRData=0x8C220004, BusErr=0, StallI high from request until the IDone cycle.
- D write DAddr=0x100, DWData=0xDEADBEEF, ready after 1 cycle → MemWe=1 and MemAddr/MemWData stable for the whole BUSY period, DDone pulse, DRData=0.
- IReq and DReq both held continuously with MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I…, streak counter clears after each I grant.
- MemReady never asserted, TIMEOUT=64 → MemReq high for exactly 64 cycles, then the owner's Done with BusErr=1 and RData=0, then IDLE.
- Reset pulsed during BUSY of a D access → MemReq=0 the next cycle, no DDone, late MemReady ignored, next pending IReq granted normally.
- MemReady on the same cycle as the timeout limit, MemRData=0x1234 → Done with BusErr=0 and RData=0x1234.
